// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: word type, FSM states, queue entry.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t NOP_INST = 32'h0000_0013;
    localparam word_t PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DROP   = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        word_t inst;
        word_t pc;
    } fetch_entry_t;

    function automatic logic is_aligned(input word_t addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request channel and decode-side instruction channel.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic  imem_req;
    word_t imem_addr;
    logic  imem_ready;
    word_t imem_rdata;
    word_t inst;
    word_t inst_pc;
    logic  inst_valid;
    logic  inst_ready;

    modport master (
        output imem_req, imem_addr, inst, inst_pc, inst_valid,
        input  imem_ready, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst, inst_pc, inst_valid,
        output imem_ready, imem_rdata, inst_ready
    );
endinterface

// File: rtl/fetch_unit_queue.sv
// Prefetch FIFO of {inst, pc}; flush overrides push and pop in the same cycle.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == CNT_W'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-outstanding imem handshake, redirect/halt/fault FSM
// and a prefetch queue feeding decode with a valid/ready handshake.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t       RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect,
    input  word_t        redirect_pc,
    input  logic         halt,
    fetch_unit_if.master bus,
    output logic         fetch_fault
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_state_t     state_q, state_d;
    word_t            pc_q, pc_d;
    word_t            drop_addr_q, drop_addr_d;
    logic             halt_pend_q, halt_pend_d;
    logic             live_q;

    logic             req_c;
    logic             done_c;
    logic             outstanding_c;
    logic             inst_valid_c;
    logic             q_push, q_pop, q_flush;
    fetch_entry_t     q_head;
    logic [CNT_W-1:0] q_count;
    logic             q_full, q_empty;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data ('{inst: bus.imem_rdata, pc: pc_q}),
        .pop       (q_pop),
        .flush     (q_flush),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // live_q holds off the first request until one full cycle out of reset.
    always_comb begin
        case (state_q)
            FETCH:   req_c = live_q && (q_count < CNT_W'(DEPTH));
            DROP:    req_c = 1'b1;
            default: req_c = 1'b0;
        endcase
    end

    assign done_c        = req_c && bus.imem_ready;
    assign outstanding_c = req_c && !bus.imem_ready;
    assign inst_valid_c  = !q_empty && (state_q != FAULT);

    assign bus.imem_req   = req_c;
    assign bus.imem_addr  = (state_q == DROP) ? drop_addr_q : pc_q;
    assign bus.inst_valid = inst_valid_c;
    assign bus.inst       = inst_valid_c ? q_head.inst : NOP_INST;
    assign bus.inst_pc    = inst_valid_c ? q_head.pc : '0;
    assign fetch_fault    = state_q == FAULT;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        halt_pend_d = halt_pend_q;
        q_push      = 1'b0;
        q_pop       = inst_valid_c && bus.inst_ready;
        q_flush     = 1'b0;

        if (redirect) begin
            q_flush     = 1'b1;
            pc_d        = redirect_pc;
            halt_pend_d = 1'b0;
            if (outstanding_c) begin
                state_d = DROP;
                if (state_q != DROP) drop_addr_d = pc_q;
            end else begin
                state_d = is_aligned(redirect_pc) ? FETCH : FAULT;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (done_c) begin
                        q_push = !q_full;
                        pc_d   = pc_q + PC_STEP;
                    end
                    // A halt waits for the live request to land before parking.
                    if (halt || halt_pend_q) begin
                        if (outstanding_c) begin
                            halt_pend_d = 1'b1;
                        end else begin
                            halt_pend_d = 1'b0;
                            state_d     = HALTED;
                        end
                    end
                end
                DROP: begin
                    if (halt) halt_pend_d = 1'b1;
                    if (done_c) begin
                        if (!is_aligned(pc_q)) begin
                            state_d     = FAULT;
                            halt_pend_d = 1'b0;
                        end else if (halt || halt_pend_q) begin
                            state_d     = HALTED;
                            halt_pend_d = 1'b0;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
                HALTED:  state_d = HALTED;
                FAULT:   state_d = FAULT;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            drop_addr_q <= '0;
            halt_pend_q <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            halt_pend_q <= halt_pend_d;
            live_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam word_t       RST_PC = 32'h0000_0100;
    localparam int unsigned DEPTH  = 2;

    logic  clk = 1'b0;
    logic  rst;
    logic  redirect;
    word_t redirect_pc;
    logic  halt;
    logic  fetch_fault;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .bus         (bus),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input word_t act, input word_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural view of what fetch must present.
    fetch_entry_t mq[$];
    word_t m_pc, m_drop_addr;
    bit    m_started, m_halted, m_faulted, m_drop, m_out;
    bit    e_req, e_valid, e_fault;
    word_t e_addr, e_inst, e_ipc;

    function automatic word_t mem_word(input word_t a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_pc      = RST_PC;
        m_drop_addr = '0;
        m_started = 1'b0;
        m_halted  = 1'b0;
        m_faulted = 1'b0;
        m_drop    = 1'b0;
        m_out     = 1'b0;
    endfunction

    function automatic void model_outputs();
        e_fault = m_faulted;
        e_req   = m_started && !m_faulted &&
                  (m_drop || m_out || (!m_halted && mq.size() < int'(DEPTH)));
        e_addr  = m_drop ? m_drop_addr : m_pc;
        e_valid = !m_faulted && mq.size() > 0;
        e_inst  = e_valid ? mq[0].inst : NOP_INST;
        e_ipc   = e_valid ? mq[0].pc : '0;
    endfunction

    function automatic void model_step();
        bit req, rdy, pop;
        if (rst) begin
            model_reset();
            return;
        end
        req = e_req;
        rdy = bus.imem_ready;
        pop = e_valid && bus.inst_ready;
        m_started = 1'b1;
        if (redirect) begin
            mq.delete();
            if (req && !rdy) m_drop_addr = e_addr;
            m_drop    = req && !rdy;
            m_pc      = redirect_pc;
            m_out     = 1'b0;
            m_halted  = 1'b0;
            m_faulted = !m_drop && (redirect_pc[1:0] != 2'b00);
            return;
        end
        if (pop) void'(mq.pop_front());
        if (req && rdy) begin
            if (m_drop) begin
                m_drop    = 1'b0;
                m_faulted = m_pc[1:0] != 2'b00;
            end else begin
                mq.push_back('{inst: bus.imem_rdata, pc: m_pc});
                m_pc = m_pc + 32'd4;
            end
            m_out = 1'b0;
        end else begin
            m_out = req && !m_drop;
        end
        if (halt) m_halted = 1'b1;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        model_outputs();
    endtask

    task automatic drive_mem(input bit rdy);
        bus.imem_ready = rdy;
        bus.imem_rdata = (rdy && e_req) ? mem_word(e_addr) : word_t'($urandom());
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; halt = 1'b0;
        drive_mem(1'b0);
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("imem_req", 32'(bus.imem_req), 32'(e_req));
            if (e_req) check("imem_addr", bus.imem_addr, e_addr);
            check("inst_valid", 32'(bus.inst_valid), 32'(e_valid));
            check("inst", bus.inst, e_inst);
            check("inst_pc", bus.inst_pc, e_ipc);
            check("fetch_fault", 32'(fetch_fault), 32'(e_fault));
        end
    end

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        bus.imem_ready = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
        cycle();
        chk_en = 1'b1;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst", bus.inst, 32'h0000_0013);
        check("rst_fault", 32'(fetch_fault), 32'd0);

        // Back-to-back fetch, one instruction per cycle.
        rst = 1'b0; bus.inst_ready = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            check("t1_req", 32'(bus.imem_req), 32'd1);
            check("t1_addr", bus.imem_addr, 32'h100 + 32'(4 * i));
            if (i > 0) check("t1_inst_pc", bus.inst_pc, 32'h100 + 32'(4 * (i - 1)));
            drive_mem(1'b1);
            cycle();
        end

        // Decode stalled: queue fills to DEPTH, then drains in order.
        do_reset();
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_mem(1'b1);
            cycle();
        end
        check("t2_req_full", 32'(bus.imem_req), 32'd0);
        check("t2_addr", bus.imem_addr, 32'h108);
        check("t2_head", bus.inst_pc, 32'h100);
        bus.inst_ready = 1'b1;
        drive_mem(1'b1);
        cycle();
        check("t2_head2", bus.inst_pc, 32'h104);
        check("t2_resume", bus.imem_addr, 32'h108);
        drive_mem(1'b1);
        cycle();
        check("t2_head3", bus.inst_pc, 32'h108);

        // Redirect with a slow response outstanding.
        do_reset();
        drive_mem(1'b1);
        cycle();
        drive_mem(1'b0);
        redirect = 1'b1; redirect_pc = 32'h200;
        cycle();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("t3_hold_addr", bus.imem_addr, 32'h104);
            check("t3_flushed", 32'(bus.inst_valid), 32'd0);
            drive_mem(1'b0);
            cycle();
        end
        drive_mem(1'b1);
        cycle();
        check("t3_new_addr", bus.imem_addr, 32'h200);
        check("t3_discard", 32'(bus.inst_valid), 32'd0);
        drive_mem(1'b1);
        cycle();
        check("t3_first_pc", bus.inst_pc, 32'h200);

        // Misaligned redirect faults until an aligned one.
        drive_mem(1'b1);
        redirect = 1'b1; redirect_pc = 32'h302;
        cycle();
        redirect = 1'b0;
        drive_mem(1'b0);
        cycle();
        check("t4_fault", 32'(fetch_fault), 32'd1);
        check("t4_req", 32'(bus.imem_req), 32'd0);
        check("t4_valid", 32'(bus.inst_valid), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h300;
        cycle();
        redirect = 1'b0;
        check("t4_clear", 32'(fetch_fault), 32'd0);
        check("t4_addr", bus.imem_addr, 32'h300);

        // Halt with a request in flight: it lands, then fetch stops.
        bus.inst_ready = 1'b0;
        halt = 1'b1;
        drive_mem(1'b0);
        cycle();
        halt = 1'b0;
        check("t5_still_req", 32'(bus.imem_req), 32'd1);
        drive_mem(1'b1);
        cycle();
        check("t5_enq", bus.inst_pc, 32'h300);
        for (int i = 0; i < 3; i++) begin
            check("t5_no_req", 32'(bus.imem_req), 32'd0);
            drive_mem(1'b0);
            bus.inst_ready = 1'b1;
            cycle();
        end
        redirect = 1'b1; redirect_pc = 32'h40;
        cycle();
        redirect = 1'b0;
        check("t5_resume", bus.imem_addr, 32'h40);

        // PC wraps from the top of the address space.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        drive_mem(1'b1);
        cycle();
        redirect = 1'b0;
        check("t6_top", bus.imem_addr, 32'hFFFF_FFFC);
        drive_mem(1'b1);
        cycle();
        check("t6_wrap", bus.imem_addr, 32'h0);
        check("t6_pc", bus.inst_pc, 32'hFFFF_FFFC);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            rst            = ($urandom_range(0, 199) == 0);
            redirect       = ($urandom_range(0, 19) == 0);
            redirect_pc    = {20'h0, 10'($urandom()), ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
            halt           = ($urandom_range(0, 29) == 0);
            bus.inst_ready = ($urandom_range(0, 9) < 7);
            drive_mem($urandom_range(0, 9) < 6);
            cycle();
        end
        rst = 1'b0; redirect = 1'b0; halt = 1'b0;
        drive_mem(1'b0);
        cycle();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
